// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush/forward sequencer for the 5-stage pipeline (F,D,E,M,W), optional perf counters via HAZ_PERF_CNT_EN.
// Latency : stall/flush/forward outputs are combinational on the current inputs; wait state, mem_timeout and counters update on the rising edge.
// Backpressure: a data-memory access that is not ready freezes F..M and bubbles W until ready or TIMEOUT_CYCLES stalled cycles.
module pipe_hazard_ctrl #(
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic [REG_W-1:0] rs_E,
  input  logic [REG_W-1:0] rt_E,
  input  logic             RegWr_E,
  input  logic             MemtoReg_E,
  input  logic [REG_W-1:0] RegWrDst_E,
  input  logic             RegWr_M,
  input  logic             MemtoReg_M,
  input  logic             MemWr_M,
  input  logic [REG_W-1:0] RegWrDst_M,
  input  logic             RegWr_W,
  input  logic [REG_W-1:0] RegWrDst_W,
  input  logic             br_taken_M,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic             pc_redirect,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic             mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]      cnt_loaduse,
  output logic [15:0]      cnt_memwait,
  output logic [15:0]      cnt_redirect
`endif
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic       r_mem_timeout;
  logic       w_timeout_set;
  // One-cycle grace after a timeout: the stuck access counts as done so the pipe can move it out of M.
  logic       r_resume;
  logic       w_resume_nxt;

  logic       w_mem_op;
  logic       w_mem_block;
  logic       w_load_use;
  logic       w_mem_stall;
  logic       w_eval;
  logic       w_redirect;
  logic       w_lu_stall;

  assign w_mem_op    = MemtoReg_M | MemWr_M;
  assign w_mem_block = w_mem_op & ~dmem_ready & ~r_resume;
  assign w_load_use  = RegWr_E & MemtoReg_E & (RegWrDst_E != '0) &
                       ((use_rs_D & (rs_D == RegWrDst_E)) | (use_rt_D & (rt_D == RegWrDst_E)));

  // Forwarding select for one E-stage source: M result beats W data, $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             wr_m,
    input logic             ld_m,
    input logic [REG_W-1:0] dst_m,
    input logic             wr_w,
    input logic [REG_W-1:0] dst_w
  );
    if (wr_m && !ld_m && (dst_m != '0) && (dst_m == src)) begin
      return 2'b10;
    end else if (wr_w && (dst_w != '0) && (dst_w == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Next-state logic: decides whether this cycle is a memory stall or a normal hazard-evaluation cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_set  = 1'b0;
    w_resume_nxt   = 1'b0;
    w_mem_stall    = 1'b0;
    w_eval         = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_block) begin
          w_mem_stall    = 1'b1;
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = 8'd1;
        end else begin
          w_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          // The access completes and the M instruction advances, so hazards
          // (including a branch held in M) are evaluated as in a normal cycle.
          w_eval         = 1'b1;
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = 8'd0;
        end else if (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          w_mem_stall    = 1'b1;
          w_timeout_set  = 1'b1;
          w_resume_nxt   = 1'b1;
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          w_mem_stall    = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign w_redirect = w_eval & br_taken_M;
  assign w_lu_stall = w_eval & ~br_taken_M & w_load_use;

  assign stall_F     = ~rst & (w_mem_stall | w_lu_stall);
  assign stall_D     = ~rst & (w_mem_stall | w_lu_stall);
  assign stall_E     = ~rst & w_mem_stall;
  assign stall_M     = ~rst & w_mem_stall;
  assign flush_D     = rst | w_redirect;
  assign flush_E     = rst | w_redirect | w_lu_stall;
  assign flush_M     = rst | w_redirect;
  assign flush_W     = rst | w_mem_stall;
  assign pc_redirect = ~rst & w_redirect;
  assign fwdA_E      = rst ? 2'b00 : fwd_sel(rs_E, RegWr_M, MemtoReg_M, RegWrDst_M, RegWr_W, RegWrDst_W);
  assign fwdB_E      = rst ? 2'b00 : fwd_sel(rt_E, RegWr_M, MemtoReg_M, RegWrDst_M, RegWr_W, RegWrDst_W);
  assign mem_timeout = r_mem_timeout;

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
      r_resume      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= r_mem_timeout | w_timeout_set;
      r_resume      <= w_resume_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic        w_memwait_ev;
  logic [15:0] r_cnt_loaduse;
  logic [15:0] r_cnt_memwait;
  logic [15:0] r_cnt_redirect;

  assign w_memwait_ev = (r_state == MEM_WAIT) | ((r_state == RUN) & w_mem_block);

  // Saturating event counters for load-use stalls, memory-wait cycles and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_loaduse  <= 16'd0;
      r_cnt_memwait  <= 16'd0;
      r_cnt_redirect <= 16'd0;
    end else begin
      if (w_lu_stall && (r_cnt_loaduse != 16'hFFFF)) r_cnt_loaduse <= r_cnt_loaduse + 16'd1;
      if (w_memwait_ev && (r_cnt_memwait != 16'hFFFF)) r_cnt_memwait <= r_cnt_memwait + 16'd1;
      if (w_redirect && (r_cnt_redirect != 16'hFFFF)) r_cnt_redirect <= r_cnt_redirect + 16'd1;
    end
  end

  assign cnt_loaduse  = r_cnt_loaduse;
  assign cnt_memwait  = r_cnt_memwait;
  assign cnt_redirect = r_cnt_redirect;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward sequencer for the 5-stage MIPS pipeline (F, D, E, M, W).
- Drives hold and bubble controls on the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Selects ALU operand forwarding in E.
- Contains a small FSM that freezes the pipe while data memory is not ready, and redirects fetch when a taken branch/jump resolves in M.

Parameters:
- REG_W, 5, register-specifier width.
- TIMEOUT_CYCLES, 16, maximum MEM_WAIT cycles before timeout; legal range 2..255.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- rs_D, rt_D  in  REG_W each  source specifiers of the instruction in D.
- use_rs_D, use_rt_D  in  1 each  D instruction actually reads rs/rt.
- rs_E, rt_E  in  REG_W each  source specifiers in E.
- RegWr_E, MemtoReg_E  in  1 each  E-stage write-enable / load flag.
- RegWrDst_E  in  REG_W  E destination.
- RegWr_M, MemtoReg_M, MemWr_M  in  1 each  M-stage controls.
- RegWrDst_M  in  REG_W  M destination.
- RegWr_W  in  1  W-stage write-enable.
- RegWrDst_W  in  REG_W  W destination.
- br_taken_M  in  1  taken branch/jump resolved in M, from NPCop_M/zero_M.
- dmem_ready  in  1  data memory completes access this cycle.
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold PC / stage register.
- flush_D, flush_E, flush_M, flush_W  out  1 each  load bubble (all controls 0) into IF/ID, ID/EX, EX/MEM, MEM/WB.
- pc_redirect  out  1  select branch target as next PC.
- fwdA_E, fwdB_E  out  2 each  operand source: 00 regfile, 10 M result, 01 W data.
- mem_timeout  out  1  sticky memory timeout flag.

Behaviour:
- FSM states:
  - RUN: normal flow.
  - MEM_WAIT: memory stall.
- Counter: wait_cnt, 8 bit.
- Reset (rst=1 at clock edge):
  - state=RUN, wait_cnt=0, mem_timeout=0.
  - While rst is high: all stall_* = 0; flush_D/E/M/W = 1; pc_redirect=0; fwd* = 00.
- mem_op_M = MemtoReg_M | MemWr_M.
- RUN:
  - If mem_op_M & !dmem_ready, the controller is in memory wait:
    - Outputs: stall_F=stall_D=stall_E=stall_M=1, flush_W=1, all other flushes 0.
    - Next state MEM_WAIT, wait_cnt=1.
  - Else if br_taken_M:
    - Outputs: pc_redirect=1, flush_D=flush_E=flush_M=1, no stalls.
    - Next state RUN. Wrong-path instructions in F/D/E are discarded on that edge.
  - Else if load-use:
    - Load-use condition: RegWr_E & MemtoReg_E & RegWrDst_E!=0 & ((use_rs_D & rs_D==RegWrDst_E) | (use_rt_D & rt_D==RegWrDst_E)).
    - Outputs: stall_F=stall_D=1, flush_E=1 for exactly that cycle.
    - The load then advances to M, and forwarding resolves the next cycle.
  - Else all stall/flush = 0.
- MEM_WAIT:
  - Same stall outputs as memory wait in RUN. Branch and load-use detection are suppressed.
  - dmem_ready=1: outputs that cycle are stalls=0, flush_W=0; next state RUN; wait_cnt=0.
  - dmem_ready=0 and wait_cnt==TIMEOUT_CYCLES-1: set mem_timeout=1 and force RUN. The access is treated as complete and the pipe resumes.
  - Otherwise wait_cnt increments.
- Priority: rst > memory wait > br_taken_M > load-use. Branch and memory op in M are exclusive by ISA; if both assert, memory wait wins and the redirect is taken once ready.
- Forwarding is combinational, evaluated independently for rs_E→fwdA_E and rt_E→fwdB_E:
  - 10 if RegWr_M & !MemtoReg_M & RegWrDst_M!=0 & RegWrDst_M==src.
  - Else 01 if RegWr_W & RegWrDst_W!=0 & RegWrDst_W==src.
  - Else 00.
  - M has priority over W. Register 0 never forwards.
- mem_timeout clears only on rst.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds three 16-bit outputs: cnt_loaduse, cnt_memwait, cnt_redirect.
  - Incremented on each cycle whose corresponding condition drives outputs (load-use stall, MEM_WAIT or entry cycle, redirect).
  - Saturate at 16'hFFFF; cleared by rst.
- When undefined: ports and logic are absent; functional behaviour is identical.

Test Plan:
- Load-use: E has lw into $8 (RegWr_E=MemtoReg_E=1, RegWrDst_E=8); D has rs_D=8, use_rs_D=1, dmem_ready=1.
  - That cycle: stall_F=stall_D=flush_E=1.
  - Next cycle: all 0; fwdA_E=01 once the load reaches W.
- Forward priority: rs_E=5, RegWr_M=1 with RegWrDst_M=5, RegWr_W=1 with RegWrDst_W=5 → fwdA_E=10. Same with RegWrDst=0 → fwdA_E=00.
- Memory wait: MemtoReg_M=1, dmem_ready low for 3 cycles then high.
  - 3 cycles with all four stalls=1 and flush_W=1.
  - The ready cycle has no stalls.
  - State returns to RUN.
- Timeout: MemWr_M=1 with dmem_ready held 0 and TIMEOUT_CYCLES=16.
  - mem_timeout rises after 16 stalled cycles; stalls drop the next cycle.
  - Flag stays 1 until rst.
- Branch: br_taken_M=1 alongside a load-use condition in D/E → pc_redirect=1, flush_D/E/M=1, stall_F=0, for exactly 1 cycle.
- Reset mid-wait: assert rst during MEM_WAIT → next cycle state RUN, wait_cnt=0, flushes=1 while rst high; perf counters (if enabled) are 0.
